mii_frame_rx: RTL and testbench

Byte-stream frame receiver: the receive-side counterpart of the team's registered `txd`/`tx_en` transmit path. It samples an MII-style `rxd`/`rx_dv` stream and qualifies the preamble and start-of-frame delimiter (SFD). It strips the trailing checksum byte and delivers the payload as a `valid`/`sop`/`eop` byte stream, with per-frame length and error status. It sits between the line-side pins and the packet consumer, in the same clock domain as the transmitter.

---
 rtl/mii_frame_rx.sv | 191 +++++++++++++++++++
 tb/tb_mii_frame_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_frame_rx.sv
// MII-style receive path: preamble/SFD qualification, checksum strip,
// payload delivery as a valid/sop/eop byte stream with length and status.
module mii_frame_rx #(
  parameter int          DW       = 8,
  parameter logic [DW-1:0] PRE_BYTE = 8'h55,
  parameter logic [DW-1:0] SFD_BYTE = 8'hD5,
  parameter int          PRE_MIN  = 7,
  parameter int          MAX_LEN  = 1500,
  parameter int          LW       = 16
) (
  input  logic          clk,
  input  logic          rst_en,
  input  logic          en,
  input  logic [DW-1:0] rxd,
  input  logic          rx_dv,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_err,
  output logic [LW-1:0] frame_len,
  output logic [7:0]    drop_cnt
);

  localparam int PW = $clog2(PRE_MIN + 1);

  typedef enum logic [1:0] {
    IDLE, PREAMBLE, DATA, DROP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [DW-1:0] h0_q, h0_d;
  logic [DW-1:0] h1_q, h1_d;
  logic [1:0]    held_q, held_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    drop_q, drop_d;
  logic          drop_inc;

  logic [DW-1:0] sum_add;
  logic [LW-1:0] cnt_inc;

  assign sum_add = sum_q + h1_q;
  assign cnt_inc = cnt_q + LW'(1);

  // Next-state and registered-output computation for the receive FSM
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    held_d    = held_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    err_d     = err_q;
    len_d     = len_q;
    drop_inc  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (rx_dv) begin
            if (rxd == PRE_BYTE) begin
              state_d   = PREAMBLE;
              pre_cnt_d = PW'(1);
            end else begin
              state_d  = DROP;
              drop_inc = 1'b1;
            end
          end
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            state_d = IDLE;
          end else if (rxd == PRE_BYTE) begin
            if (pre_cnt_q < PW'(PRE_MIN))
              pre_cnt_d = pre_cnt_q + PW'(1);
          end else if (rxd == SFD_BYTE &&
                       pre_cnt_q >= PW'(PRE_MIN)) begin
            state_d = DATA;
            held_d  = 2'd0;
            cnt_d   = '0;
            sum_d   = '0;
            h0_d    = '0;
            h1_d    = '0;
          end else begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end
        end
        DATA: begin
          if (rx_dv) begin
            if (held_q == 2'd2) begin
              data_d  = h1_q;
              valid_d = 1'b1;
              sop_d   = (cnt_q == '0);
              sum_d   = sum_add;
              cnt_d   = cnt_inc;
              if (cnt_q == LW'(MAX_LEN)) begin
                eop_d   = 1'b1;
                err_d   = 1'b1;
                len_d   = cnt_inc;
                state_d = DROP;
              end
            end else begin
              held_d = held_q + 2'd1;
            end
            h1_d = h0_q;
            h0_d = rxd;
          end else begin
            state_d = IDLE;
            if (held_q == 2'd2) begin
              data_d  = h1_q;
              valid_d = 1'b1;
              sop_d   = (cnt_q == '0);
              eop_d   = 1'b1;
              err_d   = (h0_q != sum_add);
              len_d   = cnt_inc;
              sum_d   = sum_add;
              cnt_d   = cnt_inc;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
        DROP: begin
          if (!rx_dv)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    drop_d = drop_q;
    if (drop_inc && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  // State and output registers; async active-low clear
  always_ff @(posedge clk or negedge rst_en) begin
    if (!rst_en) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      held_q    <= 2'd0;
      sum_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      held_q    <= held_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
      len_q     <= len_d;
      drop_q    <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_err   = err_q;
  assign frame_len = len_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mii_frame_rx.sv
// Directed bench for mii_frame_rx: clean/bad frames, preamble faults,
// overlength, enable gating, back-to-back frames, async reset.
module tb_mii_frame_rx;

  logic       clk = 1'b0;
  logic       rst_en = 1'b0;
  logic       en = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       rx_dv = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;
  logic [15:0] frame_len;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  mii_frame_rx #(.MAX_LEN(4)) dut (
    .clk       (clk),
    .rst_en    (rst_en),
    .en        (en),
    .rxd       (rxd),
    .rx_dv     (rx_dv),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err),
    .frame_len (frame_len),
    .drop_cnt  (drop_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] got_q[$];
  int         len_q[$];
  int         err_q[$];
  int         sop_n;
  int         eop_n;
  logic [7:0] sop_dat;
  logic [7:0] eop_dat;
  logic [7:0] tx_q[$];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_en && out_valid) begin
      got_q.push_back(out_data);
      if (out_sop) begin
        sop_n++;
        sop_dat = out_data;
      end
      if (out_eop) begin
        eop_n++;
        eop_dat = out_data;
        len_q.push_back(int'(frame_len));
        err_q.push_back(int'(out_err));
      end
    end
  end

  task automatic mon_clear();
    got_q.delete();
    len_q.delete();
    err_q.delete();
    sop_n = 0;
    eop_n = 0;
    sop_dat = 8'h00;
    eop_dat = 8'h00;
  endtask

  function automatic int gv(input int i);
    return (i < got_q.size()) ? int'(got_q[i]) : -1;
  endfunction

  function automatic int lv(input int i);
    return (i < len_q.size()) ? len_q[i] : -1;
  endfunction

  function automatic int ev(input int i);
    return (i < err_q.size()) ? err_q[i] : -1;
  endfunction

  task automatic cyc(input logic dv, input logic [7:0] d,
                     input logic e);
    rx_dv = dv;
    rxd   = d;
    en    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic dv, input logic [7:0] d,
                     input bit gated);
    cyc(dv, d, 1'b1);
    if (gated)
      cyc(dv, d, 1'b0);
  endtask

  task automatic send(input int npre, input logic [7:0] sfd,
                      input bit gated);
    for (int i = 0; i < npre; i++)
      put(1'b1, 8'h55, gated);
    put(1'b1, sfd, gated);
    foreach (tx_q[i])
      put(1'b1, tx_q[i], gated);
    put(1'b0, 8'h00, gated);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    mon_clear();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_eop", int'(out_eop), 0);
    check("rst_len", int'(frame_len), 0);
    check("rst_drop", int'(drop_cnt), 0);
    rst_en = 1'b1;
    idle(2);

    // clean frame
    mon_clear();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h06};
    send(7, 8'hD5, 1'b0);
    idle(3);
    check("clean_n", got_q.size(), 3);
    check("clean_d0", gv(0), 'h01);
    check("clean_d1", gv(1), 'h02);
    check("clean_d2", gv(2), 'h03);
    check("clean_sop_n", sop_n, 1);
    check("clean_sop_d", int'(sop_dat), 'h01);
    check("clean_eop_n", eop_n, 1);
    check("clean_eop_d", int'(eop_dat), 'h03);
    check("clean_err", ev(0), 0);
    check("clean_len", lv(0), 3);
    check("clean_drop", int'(drop_cnt), 0);

    // bad checksum
    mon_clear();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h07};
    send(7, 8'hD5, 1'b0);
    idle(3);
    check("badck_n", got_q.size(), 3);
    check("badck_d0", gv(0), 'h01);
    check("badck_d2", gv(2), 'h03);
    check("badck_eop_d", int'(eop_dat), 'h03);
    check("badck_err", ev(0), 1);
    check("badck_len", lv(0), 3);

    // preamble faults
    mon_clear();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h06};
    send(6, 8'hD5, 1'b0);
    idle(2);
    check("short_pre_drop", int'(drop_cnt), 1);
    tx_q.delete();
    send(0, 8'hAA, 1'b0);
    idle(2);
    check("bad_first_drop", int'(drop_cnt), 2);
    tx_q = '{8'h01};
    send(7, 8'hD5, 1'b0);
    idle(2);
    check("no_payload_drop", int'(drop_cnt), 3);
    check("faults_no_out", got_q.size(), 0);

    // overlength with MAX_LEN = 4
    mon_clear();
    tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00};
    send(7, 8'hD5, 1'b0);
    idle(3);
    check("ovl_n", got_q.size(), 5);
    check("ovl_d0", gv(0), 'h10);
    check("ovl_d4", gv(4), 'h14);
    check("ovl_eop_n", eop_n, 1);
    check("ovl_eop_d", int'(eop_dat), 'h14);
    check("ovl_err", ev(0), 1);
    check("ovl_len", lv(0), 5);
    check("ovl_drop", int'(drop_cnt), 3);

    // en gating then a back-to-back frame after a 1-cycle gap
    mon_clear();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h06};
    send(7, 8'hD5, 1'b1);
    tx_q = '{8'hA0, 8'hB1, 8'h51};
    send(7, 8'hD5, 1'b0);
    idle(3);
    check("gate_n", got_q.size(), 5);
    check("gate_d0", gv(0), 'h01);
    check("gate_d1", gv(1), 'h02);
    check("gate_d2", gv(2), 'h03);
    check("b2b_d0", gv(3), 'hA0);
    check("b2b_d1", gv(4), 'hB1);
    check("gate_sop_n", sop_n, 2);
    check("gate_eop_n", eop_n, 2);
    check("gate_len", lv(0), 3);
    check("gate_err", ev(0), 0);
    check("b2b_len", lv(1), 2);
    check("b2b_err", ev(1), 0);

    // async reset mid-DATA
    mon_clear();
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 8'h55, 1'b1);
    cyc(1'b1, 8'hD5, 1'b1);
    cyc(1'b1, 8'h01, 1'b1);
    cyc(1'b1, 8'h02, 1'b1);
    cyc(1'b1, 8'h03, 1'b1);
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_en = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_data", int'(out_data), 0);
    check("arst_drop", int'(drop_cnt), 0);
    check("arst_len", int'(frame_len), 0);
    rx_dv = 1'b0;
    @(posedge clk);
    #3;
    rst_en = 1'b1;
    idle(3);
    check("arst_no_eop", eop_n, 0);
    mon_clear();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h06};
    send(7, 8'hD5, 1'b0);
    idle(3);
    check("post_rst_n", got_q.size(), 3);
    check("post_rst_sop", sop_n, 1);
    check("post_rst_eop", eop_n, 1);
    check("post_rst_len", lv(0), 3);
    check("post_rst_err", ev(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
